pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_tick_timer.sv | 31 +++
 rtl/pwm_ramp_ctrl.sv | 137 +++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp controller: default widths and
// the ramp sequencer state encoding.
package pwm_pkg;

    localparam int COMPARE_SIZE_DEF = 8;
    localparam int PERIOD_SIZE_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_WR_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WAIT  = 3'd4
    } ramp_state_e;

endpackage

// File: rtl/pwm_tick_timer.sv
// Loadable down-counter that times the pause between ramp steps; expire is
// high during the last enabled cycle of the loaded count.
module pwm_tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    // NOTE: asynchronous active-low reset lives in the sensitivity list; sequential state uses <= only.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - ONE;
        end
    end

    assign expire = en && (count == ONE);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Steps a PWM compare value toward a commanded target, issuing a one-cycle
// write strobe per step with a programmable pause between steps.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int COMPARE_SIZE = COMPARE_SIZE_DEF,
    parameter int PERIOD_SIZE  = PERIOD_SIZE_DEF
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [COMPARE_SIZE-1:0] cmd_target,
    input  logic [COMPARE_SIZE-1:0] cmd_step,
    input  logic [PERIOD_SIZE-1:0]  cmd_period,
    input  logic                    abort,
    output logic [COMPARE_SIZE-1:0] compare_out,
    output logic                    wr,
    output logic                    busy,
    output logic                    done
);

    ramp_state_e             state;
    logic [COMPARE_SIZE-1:0] target_q;
    logic [COMPARE_SIZE-1:0] step_q;
    logic [PERIOD_SIZE-1:0]  period_q;

    logic                    timer_load;
    logic                    timer_expire;

    logic                    ramp_up;
    logic [COMPARE_SIZE:0]   cmp_ext;
    logic [COMPARE_SIZE:0]   tgt_ext;
    logic [COMPARE_SIZE:0]   step_ext;
    logic [COMPARE_SIZE:0]   up_sum;
    logic [COMPARE_SIZE:0]   down_diff;
    logic [COMPARE_SIZE-1:0] next_value;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // One extra bit lets the sum/difference be clamped to the target instead of wrapping.
    // NOTE: combinational logic uses blocking assignments, every output given a value on every path so no latch is inferred.
    always_comb begin
        ramp_up   = (target_q > compare_out);
        cmp_ext   = {1'b0, compare_out};
        tgt_ext   = {1'b0, target_q};
        if (step_q == '0) begin
            step_ext = ramp_up ? (tgt_ext - cmp_ext) : (cmp_ext - tgt_ext);
        end else begin
            step_ext = {1'b0, step_q};
        end
        up_sum    = cmp_ext + step_ext;
        down_diff = cmp_ext - step_ext;
        if (ramp_up) begin
            next_value = (up_sum > tgt_ext) ? target_q : up_sum[COMPARE_SIZE-1:0];
        end else begin
            next_value = (down_diff[COMPARE_SIZE] || (down_diff < tgt_ext))
                         ? target_q : down_diff[COMPARE_SIZE-1:0];
        end
    end

    assign timer_load = (state == ST_WR_LO) && !abort && (period_q != '0);

    pwm_tick_timer #(
        .WIDTH (PERIOD_SIZE)
    ) u_tick_timer (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .en       (state == ST_WAIT),
        .load_val (period_q),
        .expire   (timer_expire)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            target_q    <= '0;
            step_q      <= '0;
            period_q    <= '0;
            compare_out <= '0;
            wr          <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle and are raised only on the edge that earns them.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        target_q <= cmd_target;
                        step_q   <= cmd_step;
                        period_q <= cmd_period;
                        state    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (compare_out == target_q) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        compare_out <= next_value;
                        wr          <= 1'b1;
                        state       <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    wr    <= 1'b0;
                    state <= abort ? ST_IDLE : ST_WR_LO;
                end
                ST_WR_LO: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (period_q == '0) begin
                        state <= ST_STEP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (timer_expire) begin
                        state <= ST_STEP;
                    end
                end
                default: begin
                    wr    <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed and randomized ramps compared
// cycle by cycle against a timeline derived from the ramp rules.
module tb_pwm_ramp_ctrl;

    localparam int CW = 8;
    localparam int PW = 16;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] cmd_target = '0;
    logic [CW-1:0] cmd_step = '0;
    logic [PW-1:0] cmd_period = '0;
    logic          cmd_ready;
    logic          wr;
    logic          busy;
    logic          done;
    logic [CW-1:0] compare_out;

    int n_compared = 0;
    int n_mismatched = 0;
    int model_cmp = 0;
    int writes[$];

    pwm_ramp_ctrl #(
        .COMPARE_SIZE (CW),
        .PERIOD_SIZE  (PW)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .cmd_period  (cmd_period),
        .abort       (abort),
        .compare_out (compare_out),
        .wr          (wr),
        .busy        (busy),
        .done        (done)
    );

    always #5 sys_clk = ~sys_clk;

    // Sequence of values a ramp writes, from plain integer min/max arithmetic.
    function automatic void plan(input int cur, input int tgt, input int stp);
        int v;
        int s;
        writes.delete();
        v = cur;
        while (v != tgt) begin
            s = (stp == 0) ? ((tgt > v) ? tgt - v : v - tgt) : stp;
            if (tgt > v) v = (v + s > tgt) ? tgt : v + s;
            else         v = (v - s < tgt) ? tgt : v - s;
            writes.push_back(v);
        end
    endfunction

    // Value expected on compare_out after edge c (edge 0 = command accepted).
    function automatic int exp_value(input int c, input int start, input int span);
        int k;
        if (c < 1) return start;
        k = (c - 1) / span + 1;
        if (k > writes.size()) k = writes.size();
        return (k == 0) ? start : writes[k-1];
    endfunction

    task automatic run_ramp(input string name, input int tgt, input int stp, input int per,
                            input int abort_at);
        int start, n, span, last, c_end, ev;
        logic ew, ed, eb;
        start = model_cmp;
        plan(start, tgt, stp);
        n    = writes.size();
        span = 3 + per;
        last = 1 + n * span;
        c_end = (abort_at > 0) ? abort_at : last;

        @(negedge sys_clk);
        cmd_valid  = 1'b1;
        cmd_target = tgt[CW-1:0];
        cmd_step   = stp[CW-1:0];
        cmd_period = per[PW-1:0];
        @(posedge sys_clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_target = CW'($urandom);
        cmd_step   = CW'($urandom);
        cmd_period = PW'($urandom_range(0, 3));
        n_compared++;
        if ({wr, done, busy, cmd_ready, compare_out} !== {1'b0, 1'b0, 1'b1, 1'b0, start[CW-1:0]}) begin
            n_mismatched++;
            $display("FAIL %s accept: got wr=%0b done=%0b busy=%0b ready=%0b cmp=%0d, expected wr=0 done=0 busy=1 ready=0 cmp=%0d",
                     name, wr, done, busy, cmd_ready, compare_out, start);
        end

        for (int c = 1; c <= c_end + 2; c++) begin
            abort = (abort_at > 0) && (c == abort_at);
            @(posedge sys_clk);
            #1;
            abort = 1'b0;
            if (abort_at > 0 && c >= abort_at) begin
                ev = exp_value(abort_at - 1, start, span);
                ew = 1'b0; ed = 1'b0; eb = 1'b0;
            end else begin
                ev = exp_value(c, start, span);
                ew = ((c - 1) % span == 0) && ((c - 1) / span < n);
                ed = (c == last);
                eb = (c < last);
            end
            n_compared++;
            if ({wr, done, busy, cmd_ready, compare_out} !== {ew, ed, eb, !eb, ev[CW-1:0]}) begin
                n_mismatched++;
                $display("FAIL %s cycle %0d: got wr=%0b done=%0b busy=%0b ready=%0b cmp=%0d, expected wr=%0b done=%0b busy=%0b ready=%0b cmp=%0d",
                         name, c, wr, done, busy, cmd_ready, compare_out, ew, ed, eb, !eb, ev);
            end
        end
        model_cmp = (abort_at > 0) ? exp_value(abort_at - 1, start, span) : tgt;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            cmd_valid  = 1'($urandom);
            abort      = 1'($urandom);
            cmd_target = CW'($urandom);
            cmd_step   = CW'($urandom);
            cmd_period = PW'($urandom);
            @(posedge sys_clk);
            #1;
            n_compared++;
            if ({wr, done, busy, cmd_ready, compare_out} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'd0}) begin
                n_mismatched++;
                $display("FAIL reset cycle %0d: got wr=%0b done=%0b busy=%0b ready=%0b cmp=%0d, expected wr=0 done=0 busy=0 ready=1 cmp=0",
                         i, wr, done, busy, cmd_ready, compare_out);
            end
        end
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        rst_n     = 1'b1;
        model_cmp = 0;
    endtask

    task automatic test_ramp_up();
        run_ramp("ramp_up", 10, 4, 2, 0);
    endtask

    task automatic test_ramp_down();
        run_ramp("to_250", 250, 0, 0, 0);
        run_ramp("ramp_down", 3, 100, $urandom_range(0, 3), 0);
    endtask

    task automatic test_full_scale();
        run_ramp("to_100", 100, 0, 1, 0);
        run_ramp("full_up", 255, 200, 2, 0);
        run_ramp("step0_down", 0, 0, 1, 0);
    endtask

    task automatic test_abort();
        run_ramp("abort_wait", 10, 4, 2, 4);
        run_ramp("abort_wr_hi", 10, 4, 2, 2);
    endtask

    task automatic test_idle_abort();
        int v;
        v = model_cmp;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            abort = 1'b1;
            @(posedge sys_clk);
            #1;
            n_compared++;
            if ({wr, done, busy, compare_out} !== {1'b0, 1'b0, 1'b0, v[CW-1:0]}) begin
                n_mismatched++;
                $display("FAIL idle_abort cycle %0d: got wr=%0b done=%0b busy=%0b cmp=%0d, expected wr=0 done=0 busy=0 cmp=%0d",
                         i, wr, done, busy, compare_out, v);
            end
        end
        @(negedge sys_clk);
        cmd_valid  = 1'b1;
        cmd_target = v[CW-1:0];
        cmd_step   = CW'($urandom);
        cmd_period = PW'($urandom_range(0, 3));
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        n_compared++;
        if (busy !== 1'b1) begin
            n_mismatched++;
            $display("FAIL abort_with_cmd accept: got busy=%0b, expected busy=1", busy);
        end
        @(posedge sys_clk);
        #1;
        n_compared++;
        if ({wr, done, busy} !== 3'b010) begin
            n_mismatched++;
            $display("FAIL abort_with_cmd done: got wr=%0b done=%0b busy=%0b, expected wr=0 done=1 busy=0",
                     wr, done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int v;
        logic [2:0] exp_q[5];
        v = model_cmp;
        // {wr, done, busy} after the accept edge and the four edges that follow
        exp_q = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b000};
        @(negedge sys_clk);
        cmd_valid  = 1'b1;
        cmd_target = v[CW-1:0];
        cmd_step   = CW'($urandom);
        cmd_period = PW'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk);
            #1;
            if (i == 2) cmd_valid = 1'b0;
            n_compared++;
            if ({wr, done, busy, compare_out} !== {exp_q[i], v[CW-1:0]}) begin
                n_mismatched++;
                $display("FAIL back_to_back edge %0d: got wr/done/busy=%b cmp=%0d, expected %b cmp=%0d",
                         i, {wr, done, busy}, compare_out, exp_q[i], v);
            end
        end
    endtask

    task automatic test_random();
        int tgt, stp, per, ab, last;
        for (int i = 0; i < 15; i++) begin
            tgt = $urandom_range(0, 255);
            stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            per = $urandom_range(0, 4);
            plan(model_cmp, tgt, stp);
            last = 1 + writes.size() * (3 + per);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, last) : 0;
            run_ramp("random", tgt, stp, per, ab);
        end
    endtask

    task automatic test_reset_mid_ramp();
        int tgt;
        tgt = model_cmp ^ 128;
        @(negedge sys_clk);
        cmd_valid  = 1'b1;
        cmd_target = tgt[CW-1:0];
        cmd_step   = '0;
        cmd_period = 16'd2;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        n_compared++;
        if ({wr, compare_out} !== {1'b1, tgt[CW-1:0]}) begin
            n_mismatched++;
            $display("FAIL mid_reset pre: got wr=%0b cmp=%0d, expected wr=1 cmp=%0d", wr, compare_out, tgt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_compared++;
        if ({wr, busy, cmd_ready, compare_out} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_mismatched++;
            $display("FAIL mid_reset async: got wr=%0b busy=%0b ready=%0b cmp=%0d, expected wr=0 busy=0 ready=1 cmp=0",
                     wr, busy, cmd_ready, compare_out);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        model_cmp = 0;
        run_ramp("after_reset", 7, 3, 1, 0);
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_full_scale();
        test_abort();
        test_idle_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
